// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register and next-PC selection for the P5 MIPS core.
// A redirect that arrives while the hazard unit stalls is buffered and replayed on release.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             j_en,
  input  logic [31:0]      j_target,
  input  logic             jr_en,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc4,
  output logic [31:0]      pc8,
  output logic             fetch_valid,
  output logic             pend_valid,
  output logic             addr_err,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

  state_t           state_r, state_s;
  logic [31:0]      pc_r, pc_s;
  logic [31:0]      pend_target_r, pend_target_s;
  logic [CNT_W-1:0] fetch_count_r, fetch_count_s;
  logic             addr_err_r, addr_err_s;
  logic             redir_s, accept_s, fetch_valid_s;
  logic [31:0]      raw_target_s, target_s;

  // Redirect source select: jr beats j beats branch.
  always_comb begin
    redir_s = jr_en | j_en | br_taken;
    if (jr_en) begin
      raw_target_s = jr_target;
    end else if (j_en) begin
      raw_target_s = j_target;
    end else begin
      raw_target_s = br_target;
    end
    target_s = word_align(raw_target_s);
  end

  // Next-state, next-PC and capture-enable decode.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    pend_target_s = pend_target_r;
    fetch_count_s = fetch_count_r;
    accept_s      = 1'b0;
    fetch_valid_s = 1'b0;
    case (state_r)
      ST_BOOT: begin
        // Redirects seen in the boot cycle are dropped on purpose.
        state_s = ST_RUN;
      end
      ST_RUN: begin
        accept_s = redir_s;
        if (!stall) begin
          fetch_valid_s = 1'b1;
          fetch_count_s = fetch_count_r + CNT_ONE;
          if (redir_s) begin
            pc_s = target_s;
          end else begin
            pc_s = pc_r + 32'd4;
          end
        end else if (redir_s) begin
          pend_target_s = target_s;
          state_s       = ST_HOLD;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_HOLD: begin
        accept_s = redir_s;
        if (stall) begin
          // Latest redirect wins while frozen.
          if (redir_s) begin
            pend_target_s = target_s;
          end else begin
            pend_target_s = pend_target_r;
          end
        end else begin
          fetch_valid_s = 1'b1;
          fetch_count_s = fetch_count_r + CNT_ONE;
          state_s       = ST_RUN;
          if (redir_s) begin
            pc_s = target_s;
          end else begin
            pc_s = pend_target_r;
          end
        end
      end
      default: begin
        state_s = ST_BOOT;
      end
    endcase
    addr_err_s = accept_s & is_misaligned(raw_target_s);
  end

  // State, PC, pending target, counter and error pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_PC;
      pend_target_r <= 32'h0000_0000;
      fetch_count_r <= {CNT_W{1'b0}};
      addr_err_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      pend_target_r <= pend_target_s;
      fetch_count_r <= fetch_count_s;
      addr_err_r    <= addr_err_s;
    end
  end

  assign pc          = pc_r;
  assign pc4         = pc_r + 32'd4;
  assign pc8         = pc_r + 32'd8;
  assign fetch_valid = fetch_valid_s;
  assign pend_valid  = (state_r == ST_HOLD);
  assign addr_err    = addr_err_r;
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a flag-based behavioural model of the next-PC rules.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        j_en = 1'b0;
  logic [31:0] j_target = 32'h0;
  logic        jr_en = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic [31:0] pc, pc4, pc8;
  logic        fetch_valid, pend_valid, addr_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  // model state
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ptgt = 32'h0;
  logic [31:0] m_cnt = 32'h0;
  bit          m_boot = 1'b1;
  bit          m_pend = 1'b0;
  bit          m_err = 1'b0;

  pc_sequencer #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .j_en(j_en), .j_target(j_target),
    .jr_en(jr_en), .jr_target(jr_target),
    .pc(pc), .pc4(pc4), .pc8(pc8),
    .fetch_valid(fetch_valid), .pend_valid(pend_valid),
    .addr_err(addr_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // One clock edge; the model advances from the inputs held across that edge.
  task automatic tick();
    logic        r;
    logic [31:0] raw, al;
    @(posedge clk);
    r     = jr_en | j_en | br_taken;
    raw   = jr_en ? jr_target : (j_en ? j_target : br_target);
    al    = raw & 32'hFFFF_FFFC;
    m_err = 1'b0;
    if (reset) begin
      m_pc = 32'h3000; m_boot = 1'b1; m_pend = 1'b0; m_ptgt = 32'h0; m_cnt = 32'h0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!stall) begin
      m_pc   = r ? al : (m_pend ? m_ptgt : m_pc + 32'd4);
      m_pend = 1'b0;
      m_cnt  = m_cnt + 32'd1;
      m_err  = r && (raw[1:0] != 2'b00);
    end else if (r) begin
      m_pend = 1'b1;
      m_ptgt = al;
      m_err  = (raw[1:0] != 2'b00);
    end
    #1;
  endtask

  task automatic clr_redir();
    br_taken = 1'b0; j_en = 1'b0; jr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; clr_redir();
    repeat (3) tick();
    checks++; if (pc !== 32'h3000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
    checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", fetch_valid); end
    checks++; if (pend_valid !== 1'b0 || addr_err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", pend_valid, addr_err); end
    checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", fetch_count); end
    reset = 1'b0;
    #1;
    checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL boot_fv got=%b exp=0", fetch_valid); end
    tick();
    checks++; if (pc !== 32'h3000 || fetch_valid !== 1'b1) begin failures++; $display("FAIL post_boot got=%h/%b exp=3000/1", pc, fetch_valid); end
    tick();
    checks++; if (pc !== 32'h3004) begin failures++; $display("FAIL run1_pc got=%h exp=%h", pc, 32'h3004); end
    tick();
    checks++; if (pc !== 32'h3008) begin failures++; $display("FAIL run2_pc got=%h exp=%h", pc, 32'h3008); end
    checks++; if (fetch_count !== 32'd2) begin failures++; $display("FAIL run2_cnt got=%0d exp=2", fetch_count); end
  endtask

  task automatic test_branch();
    repeat (2) tick();
    checks++; if (pc !== 32'h3010 || pc8 !== 32'h3018) begin failures++; $display("FAIL br_pc8 got=%h/%h exp=3010/3018", pc, pc8); end
    br_taken = 1'b1; br_target = 32'h3040;
    tick();
    clr_redir();
    checks++; if (pc !== 32'h3040) begin failures++; $display("FAIL br_target got=%h exp=%h", pc, 32'h3040); end
    tick();
    checks++; if (pc !== 32'h3044) begin failures++; $display("FAIL br_next got=%h exp=%h", pc, 32'h3044); end
  endtask

  task automatic test_stall_redirect();
    int n = 0;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    while (pc !== 32'h3020 && n < 20) begin tick(); n++; end
    checks++; if (n >= 20) begin failures++; $display("FAIL reach_3020 got=%h exp=%h", pc, 32'h3020); end
    stall = 1'b1; j_en = 1'b1; j_target = 32'h3100;
    #1;
    checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL stall_fv got=%b exp=0", fetch_valid); end
    tick();
    clr_redir();
    for (int k = 0; k < 3; k++) begin
      checks++; if (pc !== 32'h3020 || pend_valid !== 1'b1) begin failures++; $display("FAIL hold%0d got=%h/%b exp=3020/1", k, pc, pend_valid); end
      if (k < 2) tick();
    end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'h3100 || pend_valid !== 1'b0) begin failures++; $display("FAIL release got=%h/%b exp=3100/0", pc, pend_valid); end
  endtask

  task automatic test_priority();
    jr_en = 1'b1; jr_target = 32'h3200;
    j_en = 1'b1; j_target = 32'h3300;
    br_taken = 1'b1; br_target = 32'h3400;
    tick();
    clr_redir();
    checks++; if (pc !== 32'h3200) begin failures++; $display("FAIL prio got=%h exp=%h", pc, 32'h3200); end
    stall = 1'b1; j_en = 1'b1; j_target = 32'h3100;
    tick();
    clr_redir();
    checks++; if (pend_valid !== 1'b1) begin failures++; $display("FAIL coll_pend got=%b exp=1", pend_valid); end
    stall = 1'b0; br_taken = 1'b1; br_target = 32'h3500;
    tick();
    clr_redir();
    checks++; if (pc !== 32'h3500 || pend_valid !== 1'b0) begin failures++; $display("FAIL collision got=%h/%b exp=3500/0", pc, pend_valid); end
  endtask

  task automatic test_misalign_wrap();
    jr_en = 1'b1; jr_target = 32'h3203;
    tick();
    clr_redir();
    checks++; if (pc !== 32'h3200 || addr_err !== 1'b1) begin failures++; $display("FAIL misal got=%h/%b exp=3200/1", pc, addr_err); end
    tick();
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL misal_pulse got=%b exp=0", addr_err); end
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    clr_redir();
    checks++; if (pc !== 32'hFFFF_FFFC || pc4 !== 32'h0 || pc8 !== 32'h4) begin failures++; $display("FAIL wrap_edge got=%h/%h/%h exp=fffffffc/0/4", pc, pc4, pc8); end
    tick();
    checks++; if (pc !== 32'h0000_0000) begin failures++; $display("FAIL wrap got=%h exp=%h", pc, 32'h0); end
  endtask

  task automatic test_reset_in_hold();
    stall = 1'b1; j_en = 1'b1; j_target = 32'h3600;
    tick();
    clr_redir();
    checks++; if (pend_valid !== 1'b1) begin failures++; $display("FAIL rh_pend got=%b exp=1", pend_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0; stall = 1'b0;
    checks++; if (pc !== 32'h3000 || pend_valid !== 1'b0 || fetch_valid !== 1'b0) begin failures++; $display("FAIL rh_reset got=%h/%b/%b exp=3000/0/0", pc, pend_valid, fetch_valid); end
    jr_en = 1'b1; jr_target = 32'h5003;
    tick();
    clr_redir();
    checks++; if (pc !== 32'h3000 || addr_err !== 1'b0) begin failures++; $display("FAIL rh_boot got=%h/%b exp=3000/0", pc, addr_err); end
    tick();
    checks++; if (pc !== 32'h3004 || fetch_count !== 32'd1) begin failures++; $display("FAIL rh_resume got=%h/%0d exp=3004/1", pc, fetch_count); end
  endtask

  task automatic test_random();
    logic [31:0] lo;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      stall     = ($urandom_range(0, 9) < 3);
      jr_en     = ($urandom_range(0, 9) == 0);
      j_en      = ($urandom_range(0, 7) == 0);
      br_taken  = ($urandom_range(0, 5) == 0);
      lo        = $urandom;
      jr_target = 32'h0000_3000 + (lo & 32'h0000_0FFF);
      j_target  = $urandom;
      br_target = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : 32'h0000_4000 + ($urandom & 32'h0000_03FF);
      reset     = ($urandom_range(0, 199) == 0);
      #1;
      checks++; if (fetch_valid !== (!m_boot && !stall)) begin failures++; $display("FAIL rnd_fv i=%0d got=%b exp=%b", i, fetch_valid, (!m_boot && !stall)); end
      tick();
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, pc, m_pc); end
      checks++; if (pc4 !== m_pc + 32'd4 || pc8 !== m_pc + 32'd8) begin failures++; $display("FAIL rnd_pc48 i=%0d got=%h/%h exp=%h/%h", i, pc4, pc8, m_pc + 32'd4, m_pc + 32'd8); end
      checks++; if (pend_valid !== m_pend) begin failures++; $display("FAIL rnd_pend i=%0d got=%b exp=%b", i, pend_valid, m_pend); end
      checks++; if (addr_err !== m_err) begin failures++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, addr_err, m_err); end
      checks++; if (fetch_count !== m_cnt) begin failures++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, fetch_count, m_cnt); end
    end
    reset = 1'b0; clr_redir(); stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall_redirect();
    test_priority();
    test_misalign_wrap();
    test_reset_in_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
